write_raw_control: RTL and testbench
====================================

# write_raw_control

Loader for level-0 raw tile data. Accepts an 8-bit pixel stream with a valid/ready handshake, packs pixels into 17-bit words, and writes them into the two original-image RAMs (o1 = even pixels, o2 = odd pixels) on the `clk_mmu` domain. The level-0 DWT read path later fetches these words from the RAMs. The block signals completion on `wr_over`, and the raw-read FSM waits for `wr_over == 2'b11`.

## Interface
Parameters:
- PIX_W, 8, input pixel width
- ADDR_W, 14, RAM address width
- DATA_W, 17, RAM word width
- TOTAL_WORDS, 12288, words per RAM per tile (3 components × 128×128 pixels / 4)

Ports:
- clk_mmu  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rst_syn  in  1  synchronous clear, same effect as rst, takes priority over everything except rst
- start  in  1  one-cycle pulse that begins a tile load
- pixel_in  in  PIX_W  raster-order pixel, component-major
- pixel_valid  in  1  pixel_in valid
- pixel_ready  out  1  block accepts pixel this cycle
- addra_o1_w, addra_o2_w  out  ADDR_W  RAM write addresses
- ena_o1_w, ena_o2_w  out  1  RAM enables
- wea_o1_w, wea_o2_w  out  1  RAM write enables
- dina_o1, dina_o2  out  DATA_W  RAM write data
- wr_over  out  2  bit0 = o1 complete, bit1 = o2 complete

## Operation
- FSM states: IDLE, FILL, WRITE, DONE. Reset state is IDLE.
- IDLE: `start` moves the FSM to FILL and clears the address, phase and `wr_over`.
- FILL: `pixel_ready` = 1. Each `pixel_valid & pixel_ready` accepts a pixel and increments the 2-bit `phase`.
  - phase 0 → o1 high byte, register bits [15:8]
  - phase 1 → o2 high byte
  - phase 2 → o1 low byte, bits [7:0]
  - phase 3 → o2 low byte; the transition goes to WRITE
- WRITE: lasts one cycle. `pixel_ready` = 0. Both RAMs are written at the same address.
  - dina = {1'b0, hi, lo}; bit 16 is reserved and always 0.
  - If addr == TOTAL_WORDS-1, go to DONE and set `wr_over` = 2'b11.
  - Otherwise addr + 1, phase = 0, return to FILL.
- DONE: `pixel_ready` = 0 and `wr_over` holds 2'b11. `start` restarts the load: the FSM goes to FILL with addr 0 and `wr_over` 2'b00.
- `start` in FILL or WRITE is ignored.
- `pixel_valid` outside FILL is ignored. No data is lost, because `pixel_ready` is low.
- Pixels are stored verbatim; sign extension and scaling happen downstream.
- An unknown FSM encoding recovers to IDLE on the next cycle.

## Timing
- Reset values (rst low or rst_syn high):
  - all addresses 0, all ena/wea 0, dina 0
  - `wr_over` 2'b00, `pixel_ready` 0, FSM IDLE, phase 0
- All outputs are registered except `pixel_ready`, which is decoded from the FSM state (FILL) only and never from `pixel_valid`.
- `start` sampled at cycle t → `pixel_ready` = 1 at t+1.
- 4th accepted pixel at cycle t → ena/wea/addr/dina valid during cycle t+1 for exactly one cycle → `pixel_ready` = 1 again at t+2.
- Peak throughput is 4 pixels per 5 cycles.
- Final word written at cycle t → `wr_over` = 2'b11 from t+1.
- ena and wea are asserted together, only in the WRITE cycle. At all other times ena = wea = 0 and addr/dina hold their last values.
- rst_syn mid-tile aborts immediately: the next cycle shows reset values and no partial word is written.
- Address never exceeds TOTAL_WORDS-1 and does not wrap.

## Structure
- A shared package holds:
  - FSM state constants (IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2, DONE = 2'd3)
  - TOTAL_WORDS, and the level-0 address limits 4095/8191/12287 shared with the read path
- One sub-module is natural: `pix_pack4`, the phase counter plus four byte registers, producing the hi/lo bytes for o1 and o2 and a `word_full` strobe.
- Address counter, FSM and output registers live in the top module.

## Test plan
- **Reset:**
  - Stimulus: hold rst low, drive `pixel_valid` = 1.
  - Required: all outputs 0, `pixel_ready` 0, `wr_over` 2'b00.
- **First word:**
  - Stimulus: `start`, then pixels 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Required: one cycle with ena = wea = 1, addr 0, dina_o1 = 17'h01133, dina_o2 = 17'h02244, and `pixel_ready` low in that cycle only.
- **Backpressure and gaps:**
  - Stimulus: random `pixel_valid` gaps over 16 pixels.
  - Required: exactly 4 writes at addr 0..3, byte order preserved, no write without 4 accepted pixels.
- **Full tile:**
  - Stimulus: stream 49152 pixels with value = index[7:0].
  - Required:
    - last write at addr 12287 with dina_o1 = 17'h0FCFE, dina_o2 = 17'h0FDFF
    - `wr_over` 2'b11 the next cycle
    - `pixel_ready` 0 afterwards and further pixels ignored
- **Abort:**
  - Stimulus: rst_syn pulse after 6 pixels.
  - Required: no write of the partial word, outputs at reset values. A new `start` plus 4 pixels writes at addr 0.
- **Restart from DONE:**
  - Stimulus: `start` in DONE.
  - Required: `wr_over` returns to 2'b00 and the next write goes to addr 0. A `start` pulse during FILL leaves phase and addr unchanged.

Source files
------------

// File: rtl/write_raw_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : write_raw_control_pkg
// Purpose  : Shared definitions for the level-0 raw tile loader and the
//            level-0 DWT raw-read path (FSM encoding, tile geometry).
// Contents : state_t       - loader FSM state encoding
//            c_TOTAL_WORDS - words per original-image RAM per tile
//            c_L0_ADDR_LIM_* - last word address of each colour component
// Revision : 1.0 - initial release
// ============================================================================
package write_raw_control_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 3 components x 128x128 pixels, 4 pixels per word pair (o1 + o2).
  localparam int c_TOTAL_WORDS = 12288;

  // Component boundaries inside each RAM, shared with the read path.
  localparam int c_L0_ADDR_LIM_C0 = 4095;
  localparam int c_L0_ADDR_LIM_C1 = 8191;
  localparam int c_L0_ADDR_LIM_C2 = 12287;

endpackage
`default_nettype wire

// File: rtl/write_raw_control_pix_pack4.sv
`default_nettype none
// ============================================================================
// Module   : write_raw_control_pix_pack4
// Purpose  : Collects four accepted pixels into the hi/lo bytes of one o1
//            word (even pixels) and one o2 word (odd pixels).
//            Phase 0 -> o1 hi, 1 -> o2 hi, 2 -> o1 lo, 3 -> o2 lo.
// Ports    : clk_mmu, rst (async, active-low)
//            i_clr       - synchronous clear of phase and bytes
//            i_accept    - a pixel is accepted this cycle
//            i_pix       - accepted pixel value
//            o_o1_hi/lo, o_o2_hi/lo - packed bytes
//            o_word_full - 4th pixel of a word is accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module write_raw_control_pix_pack4 #(
  parameter int PIX_W = 8
) (
  input  logic             clk_mmu,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_accept,
  input  logic [PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0] o_o1_hi,
  output logic [PIX_W-1:0] o_o1_lo,
  output logic [PIX_W-1:0] o_o2_hi,
  output logic [PIX_W-1:0] o_o2_lo,
  output logic             o_word_full
);

  logic [1:0]       r_phase;
  logic [PIX_W-1:0] r_o1_hi;
  logic [PIX_W-1:0] r_o1_lo;
  logic [PIX_W-1:0] r_o2_hi;
  logic [PIX_W-1:0] r_o2_lo;

  always_ff @(posedge clk_mmu or negedge rst) begin
    if (!rst) begin
      r_phase <= 2'd0;
      r_o1_hi <= '0;
      r_o1_lo <= '0;
      r_o2_hi <= '0;
      r_o2_lo <= '0;
    end else if (i_clr) begin
      r_phase <= 2'd0;
      r_o1_hi <= '0;
      r_o1_lo <= '0;
      r_o2_hi <= '0;
      r_o2_lo <= '0;
    end else if (i_accept) begin
      case (r_phase)
        2'd0:    r_o1_hi <= i_pix;
        2'd1:    r_o2_hi <= i_pix;
        2'd2:    r_o1_lo <= i_pix;
        default: r_o2_lo <= i_pix;
      endcase
      // Wraps 3 -> 0, so the next word starts at phase 0 by itself.
      r_phase <= r_phase + 2'd1;
    end
  end

  assign o_word_full = i_accept && (r_phase == 2'd3);

  // The o2 low byte arrives in the same cycle the word is registered into
  // the RAM output stage, so it is bypassed from the input.
  assign o_o1_hi = r_o1_hi;
  assign o_o1_lo = r_o1_lo;
  assign o_o2_hi = r_o2_hi;
  assign o_o2_lo = o_word_full ? i_pix : r_o2_lo;

endmodule
`default_nettype wire

// File: rtl/write_raw_control.sv
`default_nettype none
// ============================================================================
// Module   : write_raw_control
// Purpose  : Level-0 raw tile loader. Packs an 8-bit pixel stream into
//            17-bit words and writes them to the two original-image RAMs
//            (o1 = even pixels, o2 = odd pixels). Flags completion on wr_over.
// Ports    : clk_mmu, rst (async, active-low), rst_syn (sync clear)
//            start                 - begins a tile load from IDLE or DONE
//            pixel_in/valid/ready  - pixel stream handshake
//            addra_o*_w, ena_o*_w, wea_o*_w, dina_o* - RAM write ports
//            wr_over               - bit0 o1 complete, bit1 o2 complete
// Revision : 1.0 - initial release
// ============================================================================
module write_raw_control
  import write_raw_control_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 17,
  parameter int TOTAL_WORDS = c_TOTAL_WORDS
) (
  input  logic              clk_mmu,
  input  logic              rst,
  input  logic              rst_syn,
  input  logic              start,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  output logic [ADDR_W-1:0] addra_o1_w,
  output logic [ADDR_W-1:0] addra_o2_w,
  output logic              ena_o1_w,
  output logic              ena_o2_w,
  output logic              wea_o1_w,
  output logic              wea_o2_w,
  output logic [DATA_W-1:0] dina_o1,
  output logic [DATA_W-1:0] dina_o2,
  output logic [1:0]        wr_over
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
  localparam int                c_PAD_W     = DATA_W - 2 * PIX_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start_load;
  logic              w_accept;
  logic              w_last;
  logic              w_word_full;
  logic [PIX_W-1:0]  w_o1_hi;
  logic [PIX_W-1:0]  w_o1_lo;
  logic [PIX_W-1:0]  w_o2_hi;
  logic [PIX_W-1:0]  w_o2_lo;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addra;
  logic              r_en;
  logic [DATA_W-1:0] r_dina_o1;
  logic [DATA_W-1:0] r_dina_o2;
  logic [1:0]        r_wr_over;

  // start only matters when no load is in progress.
  assign w_start_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept     = pixel_valid && pixel_ready;
  assign w_last       = (r_addr == c_LAST_ADDR);

  write_raw_control_pix_pack4 #(
    .PIX_W (PIX_W)
  ) u_pix_pack4 (
    .clk_mmu     (clk_mmu),
    .rst         (rst),
    .i_clr       (rst_syn || w_start_load),
    .i_accept    (w_accept),
    .i_pix       (pixel_in),
    .o_o1_hi     (w_o1_hi),
    .o_o1_lo     (w_o1_lo),
    .o_o2_hi     (w_o2_hi),
    .o_o2_lo     (w_o2_lo),
    .o_word_full (w_word_full)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_mmu or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (rst_syn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    pixel_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = FILL;
      end
      FILL: begin
        pixel_ready = 1'b1;
        if (w_word_full) w_state_nxt = WRITE;
      end
      WRITE: begin
        w_state_nxt = w_last ? DONE : FILL;
      end
      DONE: begin
        if (start) w_state_nxt = FILL;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------- address and output stage
  // The word is registered on the 4th accepted pixel so that the RAM port
  // is driven during the single WRITE cycle that follows.
  always_ff @(posedge clk_mmu or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_addra   <= '0;
      r_en      <= 1'b0;
      r_dina_o1 <= '0;
      r_dina_o2 <= '0;
      r_wr_over <= 2'b00;
    end else if (rst_syn) begin
      r_addr    <= '0;
      r_addra   <= '0;
      r_en      <= 1'b0;
      r_dina_o1 <= '0;
      r_dina_o2 <= '0;
      r_wr_over <= 2'b00;
    end else begin
      r_en <= 1'b0;
      if (w_start_load) begin
        r_addr    <= '0;
        r_wr_over <= 2'b00;
      end
      if (w_word_full) begin
        r_en      <= 1'b1;
        r_addra   <= r_addr;
        r_dina_o1 <= {{c_PAD_W{1'b0}}, w_o1_hi, w_o1_lo};
        r_dina_o2 <= {{c_PAD_W{1'b0}}, w_o2_hi, w_o2_lo};
      end
      if (r_state == WRITE) begin
        if (w_last) begin
          r_wr_over <= 2'b11;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign addra_o1_w = r_addra;
  assign addra_o2_w = r_addra;
  assign ena_o1_w   = r_en;
  assign ena_o2_w   = r_en;
  assign wea_o1_w   = r_en;
  assign wea_o2_w   = r_en;
  assign dina_o1    = r_dina_o1;
  assign dina_o2    = r_dina_o2;
  assign wr_over    = r_wr_over;

endmodule
`default_nettype wire

// File: tb/tb_write_raw_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_raw_control
// Purpose  : Self-checking bench for write_raw_control. Accepted pixels are
//            collected in order; every group of four defines one expected
//            RAM word pair at the next sequential address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_raw_control;

  logic        clk_mmu = 1'b0;
  logic        rst;
  logic        rst_syn;
  logic        start;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [13:0] addra_o1_w, addra_o2_w;
  logic        ena_o1_w, ena_o2_w, wea_o1_w, wea_o2_w;
  logic [16:0] dina_o1, dina_o2;
  logic [1:0]  wr_over;

  write_raw_control dut (
    .clk_mmu     (clk_mmu),
    .rst         (rst),
    .rst_syn     (rst_syn),
    .start       (start),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .addra_o1_w  (addra_o1_w),
    .addra_o2_w  (addra_o2_w),
    .ena_o1_w    (ena_o1_w),
    .ena_o2_w    (ena_o2_w),
    .wea_o1_w    (wea_o1_w),
    .wea_o2_w    (wea_o2_w),
    .dina_o1     (dina_o1),
    .dina_o2     (dina_o2),
    .wr_over     (wr_over)
  );

  always #5 clk_mmu = ~clk_mmu;

  typedef struct packed {
    logic [13:0] a;
    logic [16:0] d1;
    logic [16:0] d2;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  int         viol  = 0;
  logic [7:0] acc_q[$];
  wr_t        wr_q[$];
  bit         prev_ena = 1'b0;
  logic [1:0] at_wr_over;
  logic [1:0] post_wr_over;

  // Reference: the k-th group of four accepted pixels p0..p3 becomes
  // o1 = {0,p0,p2}, o2 = {0,p1,p3} at address base+k.
  function automatic wr_t exp_word(input int k, input int base);
    wr_t w;
    w.a  = 14'(base + k);
    w.d1 = {1'b0, acc_q[4*k],   acc_q[4*k+2]};
    w.d2 = {1'b0, acc_q[4*k+1], acc_q[4*k+3]};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_mmu);
    #1;
  endtask

  // Records RAM writes and protocol rule breaks seen in the current cycle.
  task automatic sample();
    if (prev_ena) post_wr_over = wr_over;
    prev_ena = ena_o1_w;
    if ((ena_o1_w !== wea_o1_w) || (ena_o2_w !== ena_o1_w) || (wea_o2_w !== ena_o1_w))
      viol++;
    if (ena_o1_w === 1'b1) begin
      wr_q.push_back({addra_o1_w, dina_o1, dina_o2});
      at_wr_over = wr_over;
      if (addra_o2_w !== addra_o1_w) viol++;
      if (pixel_ready !== 1'b0) viol++;
      if (wr_q.size() > (acc_q.size() / 4)) viol++;
    end
  endtask

  task automatic run_pixels(input int n, input int valid_pct, input bit use_idx,
                            input int start_at, input int tail);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    while (sent < n && cyc < n * 20 + 100) begin
      pixel_valid = ($urandom_range(99) < valid_pct);
      pixel_in    = use_idx ? 8'(sent) : 8'($urandom);
      start       = (start_at >= 0) && (cyc == start_at);
      acc         = pixel_valid && pixel_ready;
      tick();
      cyc++;
      start = 1'b0;
      if (acc) begin
        acc_q.push_back(pixel_in);
        sent++;
      end
      sample();
    end
    pixel_valid = 1'b0;
    for (int i = 0; i < tail; i++) begin
      tick();
      sample();
    end
    total++;
    if (sent !== n) begin
      bad++;
      $display("FAIL stream_timeout: accepted=%0d required=%0d", sent, n);
    end
  endtask

  task automatic check_viol(input string name);
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL %s_protocol: violations=%0d required=0", name, viol);
    end
    viol = 0;
  endtask

  task automatic clear_and_start();
    rst_syn = 1'b1;
    tick();
    rst_syn = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    acc_q.delete();
    wr_q.delete();
    prev_ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst_syn = 1'b0; start = 1'b0;
    pixel_valid = 1'b1; pixel_in = 8'hA5;
    repeat (3) tick();
    total++;
    if (pixel_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b want=0", pixel_ready); end
    total++;
    if (wr_over !== 2'b00) begin bad++; $display("FAIL reset_wr_over: got=%b want=00", wr_over); end
    total++;
    if ({ena_o1_w, ena_o2_w, wea_o1_w, wea_o2_w} !== 4'b0000) begin
      bad++; $display("FAIL reset_enables: got=%b want=0000", {ena_o1_w, ena_o2_w, wea_o1_w, wea_o2_w});
    end
    total++;
    if ({addra_o1_w, addra_o2_w} !== 28'd0) begin
      bad++; $display("FAIL reset_addr: got=%h/%h want=0", addra_o1_w, addra_o2_w);
    end
    total++;
    if ({dina_o1, dina_o2} !== 34'd0) begin
      bad++; $display("FAIL reset_dina: got=%h/%h want=0", dina_o1, dina_o2);
    end
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({pixel_ready, ena_o1_w} !== 2'b00) begin
      bad++; $display("FAIL idle_ignores_valid: ready/ena=%b want=00", {pixel_ready, ena_o1_w});
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_first_word();
    logic [7:0] pix [4];
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (pixel_ready !== 1'b1) begin bad++; $display("FAIL start_to_ready: got=%b want=1", pixel_ready); end
    for (int i = 0; i < 4; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = pix[i];
      tick();
    end
    pixel_in = 8'h55;
    total++;
    if ({ena_o1_w, wea_o1_w, ena_o2_w, wea_o2_w, pixel_ready} !== 5'b11110) begin
      bad++; $display("FAIL first_write_strobe: ena/wea/ready=%b want=11110",
                      {ena_o1_w, wea_o1_w, ena_o2_w, wea_o2_w, pixel_ready});
    end
    total++;
    if ({addra_o1_w, addra_o2_w} !== 28'd0) begin
      bad++; $display("FAIL first_write_addr: got=%0d/%0d want=0", addra_o1_w, addra_o2_w);
    end
    total++;
    if ({dina_o1, dina_o2} !== {17'h01133, 17'h02244}) begin
      bad++; $display("FAIL first_write_data: got=%h/%h want=01133/02244", dina_o1, dina_o2);
    end
    tick();
    pixel_valid = 1'b0;
    total++;
    if ({ena_o1_w, pixel_ready} !== 2'b01) begin
      bad++; $display("FAIL first_write_one_cycle: ena/ready=%b want=01", {ena_o1_w, pixel_ready});
    end
    total++;
    if (dina_o1 !== 17'h01133) begin
      bad++; $display("FAIL dina_hold: got=%h want=01133", dina_o1);
    end
  endtask

  task automatic test_gaps();
    int nbad = 0;
    clear_and_start();
    run_pixels(16, 45, 1'b0, -1, 3);
    total++;
    if (wr_q.size() !== 4) begin
      bad++; $display("FAIL gaps_write_count: got=%0d want=4", wr_q.size());
    end
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      total++;
      if (wr_q[k] !== exp_word(k, 0)) begin
        bad++; $display("FAIL gaps_word%0d: got=%h want=%h", k, wr_q[k], exp_word(k, 0));
      end
    end
    check_viol("gaps");
    if (nbad != 0) bad++;
  endtask

  task automatic test_abort();
    clear_and_start();
    run_pixels(6, 100, 1'b0, -1, 0);
    rst_syn     = 1'b1;
    pixel_valid = 1'b1;
    tick();
    rst_syn = 1'b0;
    total++;
    if ({pixel_ready, ena_o1_w, wea_o1_w, wr_over, addra_o1_w, dina_o1, dina_o2} !== '0) begin
      bad++; $display("FAIL abort_reset_values: ready=%b ena=%b wr_over=%b addr=%0d dina=%h/%h want=all 0",
                      pixel_ready, ena_o1_w, wr_over, addra_o1_w, dina_o1, dina_o2);
    end
    sample();
    repeat (3) begin tick(); sample(); end
    pixel_valid = 1'b0;
    total++;
    if (wr_q.size() !== 1) begin
      bad++; $display("FAIL abort_partial_write: writes=%0d want=1", wr_q.size());
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_q.delete();
    wr_q.delete();
    prev_ena = 1'b0;
    run_pixels(4, 100, 1'b0, -1, 2);
    total++;
    if (wr_q.size() !== 1 || wr_q[0] !== exp_word(0, 0)) begin
      bad++; $display("FAIL abort_restart_word: writes=%0d got=%h want=%h",
                      wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, exp_word(0, 0));
    end
    check_viol("abort");
  endtask

  task automatic test_full_tile();
    int nbad = 0;
    int last;
    clear_and_start();
    run_pixels(49152, 100, 1'b1, -1, 3);
    total++;
    if (wr_q.size() !== 12288) begin
      bad++; $display("FAIL tile_write_count: got=%0d want=12288", wr_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 12288; k++)
      if (wr_q[k] !== exp_word(k, 0)) nbad++;
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL tile_words: wrong_words=%0d want=0", nbad);
    end
    last = wr_q.size() - 1;
    total++;
    if (last < 0 || wr_q[last] !== {14'd12287, 17'h0FCFE, 17'h0FDFF}) begin
      bad++; $display("FAIL tile_last_word: got=%h want=%h",
                      (last >= 0) ? wr_q[last] : '0, {14'd12287, 17'h0FCFE, 17'h0FDFF});
    end
    total++;
    if ({at_wr_over, post_wr_over} !== 4'b0011) begin
      bad++; $display("FAIL tile_wr_over_timing: at_write=%b next=%b want=00/11", at_wr_over, post_wr_over);
    end
    check_viol("tile");
    nbad = 0;
    pixel_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pixel_in = 8'($urandom);
      tick();
      if (pixel_ready !== 1'b0 || ena_o1_w !== 1'b0 || wr_over !== 2'b11) nbad++;
    end
    pixel_valid = 1'b0;
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL done_ignores_pixels: bad_cycles=%0d want=0", nbad);
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({wr_over, pixel_ready} !== 3'b001) begin
      bad++; $display("FAIL restart_from_done: wr_over=%b ready=%b want=00/1", wr_over, pixel_ready);
    end
    acc_q.delete();
    wr_q.delete();
    prev_ena = 1'b0;
    run_pixels(4, 100, 1'b0, -1, 2);
    total++;
    if (wr_q.size() !== 1 || wr_q[0] !== exp_word(0, 0)) begin
      bad++; $display("FAIL restart_first_word: writes=%0d got=%h want=%h",
                      wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, exp_word(0, 0));
    end
    acc_q.delete();
    wr_q.delete();
    run_pixels(4, 100, 1'b0, 2, 2);
    total++;
    if (wr_q.size() !== 1 || wr_q[0] !== exp_word(0, 1)) begin
      bad++; $display("FAIL start_in_fill_ignored: writes=%0d got=%h want=%h",
                      wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, exp_word(0, 1));
    end
    check_viol("restart");
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_gaps();
    test_abort();
    test_full_tile();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
